// File: rtl/magma_pkg.sv
// Shared definitions for the Magma (GOST R 34.12-2015) 64-bit block cipher.
// Contents: S-box table PI, the t (S-layer) and g round functions,
// the round-key schedule index, key-word extraction and the core FSM state.
package magma_pkg;

  localparam int BLK_W    = 64;
  localparam int KEY_W    = 256;
  localparam int N_ROUNDS = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } magma_state_t;

  // PI[i] substitutes nibble i (bits 4i+3:4i) of the 32-bit word.
  localparam logic [3:0] PI [0:7][0:15] = '{
    '{4'hC, 4'h4, 4'h6, 4'h2, 4'hA, 4'h5, 4'hB, 4'h9, 4'hE, 4'h8, 4'hD, 4'h7, 4'h0, 4'h3, 4'hF, 4'h1},
    '{4'h6, 4'h8, 4'h2, 4'h3, 4'h9, 4'hA, 4'h5, 4'hC, 4'h1, 4'hE, 4'h4, 4'h7, 4'hB, 4'hD, 4'h0, 4'hF},
    '{4'hB, 4'h3, 4'h5, 4'h8, 4'h2, 4'hF, 4'hA, 4'hD, 4'hE, 4'h1, 4'h7, 4'h4, 4'hC, 4'h9, 4'h6, 4'h0},
    '{4'hC, 4'h8, 4'h2, 4'h1, 4'hD, 4'h4, 4'hF, 4'h6, 4'h7, 4'h0, 4'hA, 4'h5, 4'h3, 4'hE, 4'h9, 4'hB},
    '{4'h7, 4'hF, 4'h5, 4'hA, 4'h8, 4'h1, 4'h6, 4'hD, 4'h0, 4'h9, 4'h3, 4'hE, 4'hB, 4'h4, 4'h2, 4'hC},
    '{4'h5, 4'hD, 4'hF, 4'h6, 4'h9, 4'h2, 4'hC, 4'hA, 4'hB, 4'h7, 4'h8, 4'h1, 4'h4, 4'h3, 4'hE, 4'h0},
    '{4'h8, 4'hE, 4'h2, 4'h5, 4'h6, 4'h9, 4'h1, 4'hC, 4'hF, 4'h4, 4'hB, 4'h0, 4'hD, 4'hA, 4'h3, 4'h7},
    '{4'h1, 4'h7, 4'hE, 4'hD, 4'h0, 4'h5, 4'h8, 4'h3, 4'h4, 4'hF, 4'hA, 4'h6, 4'h9, 4'hC, 4'hB, 4'h2}
  };

  // S-layer: each nibble through its own substitution.
  function automatic logic [31:0] magma_t(input logic [31:0] a);
    logic [31:0] res;
    res = '0;
    for (int i = 0; i < 8; i++) begin
      res[4*i +: 4] = PI[i][a[4*i +: 4]];
    end
    return res;
  endfunction

  // g(a, k) = rotl11(t(a + k mod 2^32))
  function automatic logic [31:0] magma_g(input logic [31:0] a, input logic [31:0] k);
    logic [31:0] s;
    s = magma_t(a + k);
    return {s[20:0], s[31:21]};
  endfunction

  // Round-key index. Encrypt walks k0..k7 three times then k7..k0;
  // decrypt walks k0..k7 once then k7..k0 three times.
  function automatic logic [2:0] magma_kidx(input logic [4:0] r, input logic dec);
    logic [2:0] lo;
    lo = r[2:0];
    if (dec) begin
      return (r < 5'd8) ? lo : 3'd7 - lo;
    end
    return (r < 5'd24) ? lo : 3'd7 - lo;
  endfunction

  // k0 sits in the top 32 bits of the key.
  function automatic logic [31:0] magma_kword(input logic [255:0] key, input logic [2:0] idx);
    return key[32*(3'd7 - idx) +: 32];
  endfunction

endpackage

// File: rtl/magma_round.sv
// One Magma Feistel round, purely combinational: L' = R, R' = L ^ g(R, k).
// Latency: zero cycles (chained RPC times inside the core).
// Backpressure: none; the enclosing core controls when results are registered.
// Ports: l, r = current halves; k = round key; l_next, r_next = halves after the round.
module magma_round
  import magma_pkg::*;
(
  input  logic [31:0] l,
  input  logic [31:0] r,
  input  logic [31:0] k,
  output logic [31:0] l_next,
  output logic [31:0] r_next
);

  assign l_next = r;
  assign r_next = l ^ magma_g(r, k);

endmodule

// File: rtl/magma_iter_core.sv
// Iterative Magma encrypt/decrypt core, RPC rounds per clock, 256-bit key latched per block.
// Latency: accept edge plus 32/RPC compute edges, then out_valid; one block per 32/RPC+1 cycles.
// Backpressure: result held in DONE until out_ready; in_ready follows out_ready there (same-cycle reload).
// Ports: clk, reset_ (async active-low); in_valid/in_ready/in_data/in_key/in_decrypt input side;
//        out_valid/out_ready/out_data result side; busy high while rounds are being computed.
module magma_iter_core
  import magma_pkg::*;
#(
  parameter int RPC = 1
) (
  input  logic         clk,
  input  logic         reset_,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [63:0]  in_data,
  input  logic [255:0] in_key,
  input  logic         in_decrypt,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [63:0]  out_data,
  output logic         busy
);

  localparam int         N_CYC    = N_ROUNDS / RPC;
  localparam logic [4:0] RND_STEP = 5'(RPC);
  // rnd value at the start of the cycle that computes round 31
  localparam logic [4:0] RND_LAST = 5'(RPC * (N_CYC - 1));

  if (RPC != 1 && RPC != 2 && RPC != 4 && RPC != 8) begin : g_bad_rpc
    $error("magma_iter_core: RPC must be 1, 2, 4 or 8");
  end

  magma_state_t state;
  logic [31:0]  l_q;
  logic [31:0]  r_q;
  logic [4:0]   rnd;
  logic [255:0] key_q;
  logic         dec_q;
  logic         accept;

  assign in_ready = (state == IDLE) || (state == DONE && out_ready);
  assign accept   = in_valid && in_ready;

  // Round chain: stage j computes round rnd + j. rnd never exceeds 32-RPC
  // while in RUN, so rnd + j stays inside 0..31.
  logic [31:0] l_c [RPC+1];
  logic [31:0] r_c [RPC+1];

  assign l_c[0] = l_q;
  assign r_c[0] = r_q;

  for (genvar j = 0; j < RPC; j++) begin : g_chain
    logic [2:0]  kidx;
    logic [31:0] kword;
    assign kidx  = magma_kidx(rnd + 5'(j), dec_q);
    assign kword = magma_kword(key_q, kidx);
    magma_round u_round (
      .l      (l_c[j]),
      .r      (r_c[j]),
      .k      (kword),
      .l_next (l_c[j+1]),
      .r_next (r_c[j+1])
    );
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state     <= IDLE;
      l_q       <= '0;
      r_q       <= '0;
      rnd       <= '0;
      key_q     <= '0;
      dec_q     <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      busy      <= 1'b0;
    end else begin
      // Accept only happens in IDLE or DONE, so it never collides with
      // the RUN-state updates of the same registers below.
      if (accept) begin
        l_q   <= in_data[63:32];
        r_q   <= in_data[31:0];
        key_q <= in_key;
        dec_q <= in_decrypt;
        rnd   <= '0;
      end

      case (state)
        IDLE: begin
          if (in_valid) begin
            state <= RUN;
            busy  <= 1'b1;
          end
        end

        RUN: begin
          l_q <= l_c[RPC];
          r_q <= r_c[RPC];
          rnd <= rnd + RND_STEP;  // wraps to 0 after the last step; unused until reloaded
          if (rnd == RND_LAST) begin
            // The last round has no swap, so emit the halves swapped back.
            out_data  <= {r_c[RPC], l_c[RPC]};
            out_valid <= 1'b1;
            busy      <= 1'b0;
            state     <= DONE;
          end
        end

        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (in_valid) begin
              state <= RUN;
              busy  <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_magma_iter_core.sv
`timescale 1ns/1ps
module tb_magma_iter_core;
  import magma_pkg::*;

  localparam logic [255:0] KEY1 = 256'hffeeddccbbaa99887766554433221100f0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
  localparam logic [63:0]  PT1  = 64'hfedcba9876543210;
  localparam logic [63:0]  CT1  = 64'h4ee901e5c2d8ca3d;

  logic         clk = 1'b0;
  logic         reset_;
  logic         in_valid;
  logic [63:0]  in_data;
  logic [255:0] in_key;
  logic         in_decrypt;
  logic         out_ready;
  logic [3:0]   in_ready;
  logic [3:0]   out_valid;
  logic [3:0]   busy;
  logic [63:0]  out_data [4];

  int nvec = 0;
  int nerr = 0;

  // results of the most recent wait_results call, per instance
  int          lat [4];
  logic [63:0] res [4];

  always #5 clk = ~clk;

  // Instance i runs with RPC = 2^i: 1, 2, 4, 8.
  for (genvar i = 0; i < 4; i++) begin : g_dut
    magma_iter_core #(.RPC(1 << i)) u_dut (
      .clk        (clk),
      .reset_     (reset_),
      .in_valid   (in_valid),
      .in_ready   (in_ready[i]),
      .in_data    (in_data),
      .in_key     (in_key),
      .in_decrypt (in_decrypt),
      .out_valid  (out_valid[i]),
      .out_ready  (out_ready),
      .out_data   (out_data[i]),
      .busy       (busy[i])
    );
  end

  // ---------------- reference model ----------------
  int sb [8][16] = '{
    '{12, 4, 6, 2,10, 5,11, 9,14, 8,13, 7, 0, 3,15, 1},
    '{ 6, 8, 2, 3, 9,10, 5,12, 1,14, 4, 7,11,13, 0,15},
    '{11, 3, 5, 8, 2,15,10,13,14, 1, 7, 4,12, 9, 6, 0},
    '{12, 8, 2, 1,13, 4,15, 6, 7, 0,10, 5, 3,14, 9,11},
    '{ 7,15, 5,10, 8, 1, 6,13, 0, 9, 3,14,11, 4, 2,12},
    '{ 5,13,15, 6, 9, 2,12,10,11, 7, 8, 1, 4, 3,14, 0},
    '{ 8,14, 2, 5, 6, 9, 1,12,15, 4,11, 0,13,10, 3, 7},
    '{ 1, 7,14,13, 0, 5, 8, 3, 4,15,10, 6, 9,12,11, 2}
  };

  function automatic logic [31:0] ref_g(input logic [31:0] a, input logic [31:0] k);
    logic [31:0] s;
    logic [31:0] t;
    s = a + k;
    t = 32'd0;
    for (int i = 0; i < 8; i++) begin
      t = t | (32'(sb[i][(s >> (4*i)) & 32'd15]) << (4*i));
    end
    return (t << 11) | (t >> 21);
  endfunction

  // Standard form: 31 swapping rounds G[K], then one non-swapping G*[K].
  function automatic logic [63:0] ref_crypt(input logic [63:0] d, input logic [255:0] key, input bit dec);
    logic [31:0] kw [8];
    int          order [$];
    logic [31:0] a1;
    logic [31:0] a0;
    logic [31:0] t;
    bit          fwd;
    for (int i = 0; i < 8; i++) kw[i] = key[255 - 32*i -: 32];
    for (int p = 0; p < 4; p++) begin
      fwd = dec ? (p == 0) : (p < 3);
      for (int i = 0; i < 8; i++) order.push_back(fwd ? i : 7 - i);
    end
    a1 = d[63:32];
    a0 = d[31:0];
    for (int i = 0; i < 31; i++) begin
      t  = a0;
      a0 = a1 ^ ref_g(a0, kw[order[i]]);
      a1 = t;
    end
    a1 = a1 ^ ref_g(a0, kw[order[31]]);
    return {a1, a0};
  endfunction

  function automatic logic [255:0] rand_key();
    logic [255:0] k;
    for (int i = 0; i < 8; i++) k[32*i +: 32] = $urandom;
    return k;
  endfunction

  // ---------------- stimulus helpers ----------------
  // Called #1 after the accept edge (edge number 1). Records, per instance,
  // the edge number at which out_valid is first seen and the data then.
  task automatic wait_results();
    int n;
    bit got [4];
    for (int i = 0; i < 4; i++) begin
      lat[i] = -1;
      res[i] = 'x;
      got[i] = 1'b0;
    end
    n = 1;
    while (!(got[0] && got[1] && got[2] && got[3]) && n < 100) begin
      @(posedge clk);
      n++;
      #1;
      for (int i = 0; i < 4; i++) begin
        if (!got[i] && out_valid[i]) begin
          got[i] = 1'b1;
          lat[i] = n;
          res[i] = out_data[i];
        end
      end
    end
  endtask

  // Offer one block for one cycle with out_ready high, scramble the inputs
  // right after accept, collect results, then let the slowest core drain.
  task automatic do_block(input logic [63:0] d, input logic [255:0] k, input bit dec);
    @(negedge clk);
    in_data    = d;
    in_key     = k;
    in_decrypt = dec;
    in_valid   = 1'b1;
    out_ready  = 1'b1;
    @(posedge clk);
    #1;
    in_valid   = 1'b0;
    in_data    = {$urandom, $urandom};
    in_key     = rand_key();
    in_decrypt = ~dec;
    wait_results();
    @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_     = 1'b0;
    in_valid   = 1'b0;
    in_data    = '0;
    in_key     = '0;
    in_decrypt = 1'b0;
    out_ready  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      nvec++; if (in_ready[i] !== 1'b1) begin nerr++; $display("FAIL reset_in_ready rpc%0d got %b want 1", 1 << i, in_ready[i]); end
      nvec++; if (out_valid[i] !== 1'b0) begin nerr++; $display("FAIL reset_out_valid rpc%0d got %b want 0", 1 << i, out_valid[i]); end
      nvec++; if (busy[i] !== 1'b0) begin nerr++; $display("FAIL reset_busy rpc%0d got %b want 0", 1 << i, busy[i]); end
      nvec++; if (out_data[i] !== 64'd0) begin nerr++; $display("FAIL reset_out_data rpc%0d got %h want 0", 1 << i, out_data[i]); end
    end
    @(negedge clk);
    reset_ = 1'b1;
  endtask

  task automatic test_round_unit();
    logic [31:0] t_got;
    logic [31:0] g_got;
    t_got = magma_t(32'hfdb97531);
    g_got = magma_g(32'hfedcba98, 32'h87654321);
    nvec++; if (t_got !== 32'h2a196f34) begin nerr++; $display("FAIL unit_t got %h want 2a196f34", t_got); end
    nvec++; if (g_got !== 32'hfdcbc20c) begin nerr++; $display("FAIL unit_g got %h want fdcbc20c", g_got); end
  endtask

  task automatic test_vectors();
    do_block(PT1, KEY1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      nvec++; if (res[i] !== CT1) begin nerr++; $display("FAIL enc_vec rpc%0d got %h want %h", 1 << i, res[i], CT1); end
      nvec++; if (lat[i] !== (32 >> i) + 1) begin nerr++; $display("FAIL enc_latency rpc%0d got %0d want %0d", 1 << i, lat[i], (32 >> i) + 1); end
    end
    do_block(CT1, KEY1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      nvec++; if (res[i] !== PT1) begin nerr++; $display("FAIL dec_vec rpc%0d got %h want %h", 1 << i, res[i], PT1); end
      nvec++; if (lat[i] !== (32 >> i) + 1) begin nerr++; $display("FAIL dec_latency rpc%0d got %0d want %0d", 1 << i, lat[i], (32 >> i) + 1); end
    end
  endtask

  task automatic test_random();
    logic [63:0]  d;
    logic [255:0] k;
    bit           dec;
    logic [63:0]  exp;
    for (int n = 0; n < 8; n++) begin
      d   = {$urandom, $urandom};
      k   = rand_key();
      dec = 1'($urandom_range(0, 1));
      exp = ref_crypt(d, k, dec);
      do_block(d, k, dec);
      for (int i = 0; i < 4; i++) begin
        nvec++; if (res[i] !== exp) begin nerr++; $display("FAIL random rpc%0d blk%0d dec=%0d got %h want %h", 1 << i, n, dec, res[i], exp); end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0]  d;
    logic [255:0] k;
    logic [63:0]  exp;
    d   = {$urandom, $urandom};
    k   = rand_key();
    exp = ref_crypt(d, k, 1'b0);
    @(negedge clk);
    in_data    = d;
    in_key     = k;
    in_decrypt = 1'b0;
    in_valid   = 1'b1;
    out_ready  = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    wait_results();
    for (int i = 0; i < 4; i++) begin
      nvec++; if (res[i] !== exp) begin nerr++; $display("FAIL bp_first rpc%0d got %h want %h", 1 << i, res[i], exp); end
    end
    // hold out_ready low: result must stay put and no new block may enter
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
        nvec++; if (out_valid[i] !== 1'b1) begin nerr++; $display("FAIL bp_out_valid rpc%0d cyc%0d got %b want 1", 1 << i, c, out_valid[i]); end
        nvec++; if (out_data[i] !== exp) begin nerr++; $display("FAIL bp_out_data rpc%0d cyc%0d got %h want %h", 1 << i, c, out_data[i], exp); end
        nvec++; if (in_ready[i] !== 1'b0) begin nerr++; $display("FAIL bp_in_ready rpc%0d cyc%0d got %b want 0", 1 << i, c, in_ready[i]); end
      end
    end
    // release and reload in the same cycle with the decrypt of the result
    @(negedge clk);
    in_data    = exp;
    in_decrypt = 1'b1;
    in_valid   = 1'b1;
    out_ready  = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      nvec++; if (in_ready[i] !== 1'b1) begin nerr++; $display("FAIL b2b_in_ready rpc%0d got %b want 1", 1 << i, in_ready[i]); end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = {$urandom, $urandom};
    for (int i = 0; i < 4; i++) begin
      nvec++; if (out_valid[i] !== 1'b0 || busy[i] !== 1'b1) begin nerr++; $display("FAIL b2b_reload rpc%0d got valid=%b busy=%b want valid=0 busy=1", 1 << i, out_valid[i], busy[i]); end
    end
    wait_results();
    for (int i = 0; i < 4; i++) begin
      nvec++; if (res[i] !== d) begin nerr++; $display("FAIL b2b_second rpc%0d got %h want %h", 1 << i, res[i], d); end
      nvec++; if (lat[i] !== (32 >> i) + 1) begin nerr++; $display("FAIL b2b_latency rpc%0d got %0d want %0d", 1 << i, lat[i], (32 >> i) + 1); end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid();
    bit seen [4];
    @(negedge clk);
    in_data    = PT1;
    in_key     = KEY1;
    in_decrypt = 1'b0;
    in_valid   = 1'b1;
    out_ready  = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    // twelve RUN edges: the RPC=1 core is at rnd = 12
    repeat (12) @(posedge clk);
    #2;
    reset_ = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      nvec++; if (in_ready[i] !== 1'b1 || out_valid[i] !== 1'b0 || busy[i] !== 1'b0 || out_data[i] !== 64'd0) begin
        nerr++;
        $display("FAIL midrst_outputs rpc%0d got rdy=%b vld=%b busy=%b data=%h want 1 0 0 0", 1 << i, in_ready[i], out_valid[i], busy[i], out_data[i]);
      end
      seen[i] = 1'b0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_ = 1'b1;
    repeat (40) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) if (out_valid[i]) seen[i] = 1'b1;
    end
    for (int i = 0; i < 4; i++) begin
      nvec++; if (seen[i] !== 1'b0) begin nerr++; $display("FAIL midrst_no_valid rpc%0d got pulse want none", 1 << i); end
    end
    do_block(PT1, KEY1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      nvec++; if (res[i] !== CT1) begin nerr++; $display("FAIL midrst_after rpc%0d got %h want %h", 1 << i, res[i], CT1); end
    end
  endtask

  initial begin
    test_reset();
    test_round_unit();
    test_vectors();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
